id_ex_stage: RTL and testbench

ID/EX pipeline stage of the pipelined MIPS core. Registers decoded instruction fields and control from ID, resolves data hazards, and drives the EX-stage ALU and ALU-control inputs. Forwards from EX/MEM and MEM/WB, detects load-use hazards (stall request to IF/ID), and inserts bubbles on stall or branch flush.

---
 rtl/mips_pkg.sv | 32 +++
 rtl/id_ex_stage_fwd_sel.sv | 33 +++
 rtl/id_ex_stage.sv | 169 ++++++++++++++++
 tb/tb_id_ex_stage.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared constants and types for the pipelined MIPS core: widths, opcodes,
// function codes and the control bundle carried from ID into EX.
package mips_pkg;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_LH    = 6'b100001;
    localparam logic [5:0] OP_LHU   = 6'b100101;

    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_SLT  = 6'b101010;
    localparam logic [5:0] F_SLTU = 6'b101011;
    localparam logic [5:0] F_SLL  = 6'b000000;
    localparam logic [5:0] F_SRL  = 6'b000010;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
        logic alu_src;
    } ctrl_t;

endpackage

// File: rtl/id_ex_stage_fwd_sel.sv
// Priority operand bypass: EX/MEM result beats MEM/WB result beats the
// value registered at capture. Register 0 is never bypassed.
module fwd_sel #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] i_reg,
    input  logic [DATA_W-1:0] i_reg_data,
    input  logic              i_exm_reg_write,
    input  logic [REG_AW-1:0] i_exm_rd,
    input  logic [DATA_W-1:0] i_exm_data,
    input  logic              i_mw_reg_write,
    input  logic [REG_AW-1:0] i_mw_rd,
    input  logic [DATA_W-1:0] i_mw_data,
    output logic [DATA_W-1:0] o_data
);

    logic w_exm_hit;
    logic w_mw_hit;

    assign w_exm_hit = i_exm_reg_write && (i_exm_rd != '0) && (i_exm_rd == i_reg);
    assign w_mw_hit  = i_mw_reg_write && (i_mw_rd != '0) && (i_mw_rd == i_reg);

    always_comb begin
        o_data = i_reg_data;
        if (w_exm_hit) begin
            o_data = i_exm_data;
        end else if (w_mw_hit) begin
            o_data = i_mw_data;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, WB bypass at capture,
// load-use stall detection and bubble insertion on stall/flush/invalid ID.
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int REG_AW = mips_pkg::REG_AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [5:0]        id_op,
    input  logic [5:0]        id_func,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [REG_AW-1:0] id_shamt,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [15:0]       id_imm,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              id_mem_to_reg,
    input  logic              id_alu_src,
    input  logic              id_reg_dst,
    input  logic              exm_reg_write,
    input  logic [REG_AW-1:0] exm_rd,
    input  logic [DATA_W-1:0] exm_alu_out,
    input  logic              mw_reg_write,
    input  logic [REG_AW-1:0] mw_rd,
    input  logic [DATA_W-1:0] mw_wdata,
    input  logic              flush,
    output logic              stall,
    output logic              ex_valid,
    output logic [5:0]        ex_op,
    output logic [5:0]        ex_func,
    output logic [REG_AW-1:0] ex_shamt,
    output logic [DATA_W-1:0] ex_in1,
    output logic [DATA_W-1:0] ex_in2,
    output logic [DATA_W-1:0] ex_store_data,
    output logic [REG_AW-1:0] ex_dest,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_mem_to_reg
);

    // Handshake: an ID instruction is accepted at a rising edge only when
    // id_valid=1, stall=0 and flush=0; stall=1 means IF/ID must hold its
    // contents for that edge while EX receives a bubble.

    logic              r_valid;
    logic [5:0]        r_op;
    logic [5:0]        r_func;
    logic [REG_AW-1:0] r_shamt;
    logic [REG_AW-1:0] r_rs;
    logic [REG_AW-1:0] r_rt;
    logic [REG_AW-1:0] r_dest;
    logic [DATA_W-1:0] r_rs_data;
    logic [DATA_W-1:0] r_rt_data;
    logic [15:0]       r_imm;
    ctrl_t             r_ctrl;

    logic              w_uses_rt;
    logic              w_load_use;
    logic              w_capture;
    logic [DATA_W-1:0] w_rs_bypass;
    logic [DATA_W-1:0] w_rt_bypass;
    logic [DATA_W-1:0] w_fwd_a;
    logic [DATA_W-1:0] w_fwd_b;
    logic [DATA_W-1:0] w_imm_ext;

    assign w_uses_rt  = !id_alu_src || id_mem_write;
    assign w_load_use = r_valid && r_ctrl.mem_read && (r_dest != '0) && id_valid &&
                        ((r_dest == id_rs) || (w_uses_rt && (r_dest == id_rt)));
    assign w_capture  = id_valid && !flush && !w_load_use;

    // The register file is written at the end of the cycle, so a same-cycle
    // MEM/WB write must be picked up here rather than from the read port.
    assign w_rs_bypass = (mw_reg_write && (mw_rd != '0) && (mw_rd == id_rs)) ? mw_wdata : id_rs_data;
    assign w_rt_bypass = (mw_reg_write && (mw_rd != '0) && (mw_rd == id_rt)) ? mw_wdata : id_rt_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_op      <= '0;
            r_func    <= '0;
            r_shamt   <= '0;
            r_rs      <= '0;
            r_rt      <= '0;
            r_dest    <= '0;
            r_rs_data <= '0;
            r_rt_data <= '0;
            r_imm     <= '0;
            r_ctrl    <= '0;
        end else if (w_capture) begin
            r_valid   <= 1'b1;
            r_op      <= id_op;
            r_func    <= id_func;
            r_shamt   <= id_shamt;
            r_rs      <= id_rs;
            r_rt      <= id_rt;
            r_dest    <= id_reg_dst ? id_rd : id_rt;
            r_rs_data <= w_rs_bypass;
            r_rt_data <= w_rt_bypass;
            r_imm     <= id_imm;
            r_ctrl    <= '{reg_write:  id_reg_write,
                           mem_read:   id_mem_read,
                           mem_write:  id_mem_write,
                           mem_to_reg: id_mem_to_reg,
                           alu_src:    id_alu_src};
        end else begin
            // Bubble: zeroed indices keep it from ever matching a forward.
            r_valid   <= 1'b0;
            r_op      <= '0;
            r_func    <= '0;
            r_shamt   <= '0;
            r_rs      <= '0;
            r_rt      <= '0;
            r_dest    <= '0;
            r_rs_data <= '0;
            r_rt_data <= '0;
            r_imm     <= '0;
            r_ctrl    <= '0;
        end
    end

    fwd_sel #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_a (
        .i_reg           (r_rs),
        .i_reg_data      (r_rs_data),
        .i_exm_reg_write (exm_reg_write),
        .i_exm_rd        (exm_rd),
        .i_exm_data      (exm_alu_out),
        .i_mw_reg_write  (mw_reg_write),
        .i_mw_rd         (mw_rd),
        .i_mw_data       (mw_wdata),
        .o_data          (w_fwd_a)
    );

    fwd_sel #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_b (
        .i_reg           (r_rt),
        .i_reg_data      (r_rt_data),
        .i_exm_reg_write (exm_reg_write),
        .i_exm_rd        (exm_rd),
        .i_exm_data      (exm_alu_out),
        .i_mw_reg_write  (mw_reg_write),
        .i_mw_rd         (mw_rd),
        .i_mw_data       (mw_wdata),
        .o_data          (w_fwd_b)
    );

    assign w_imm_ext = {{(DATA_W-16){r_imm[15]}}, r_imm};

    assign stall         = w_load_use;
    assign ex_valid      = r_valid;
    assign ex_op         = r_op;
    assign ex_func       = r_func;
    assign ex_shamt      = r_shamt;
    assign ex_dest       = r_dest;
    assign ex_in1        = w_fwd_a;
    assign ex_in2        = r_ctrl.alu_src ? w_imm_ext : w_fwd_b;
    assign ex_store_data = w_fwd_b;
    assign ex_reg_write  = r_ctrl.reg_write;
    assign ex_mem_read   = r_ctrl.mem_read;
    assign ex_mem_write  = r_ctrl.mem_write;
    assign ex_mem_to_reg = r_ctrl.mem_to_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: an instruction-level model of what EX must
// hold, checked every negedge, plus hand-computed literal expectations.
module tb_id_ex_stage;
  import mips_pkg::*;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic [5:0]  id_op, id_func;
  logic [4:0]  id_rs, id_rt, id_rd, id_shamt;
  logic [31:0] id_rs_data, id_rt_data;
  logic [15:0] id_imm;
  logic        id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src, id_reg_dst;
  logic        exm_reg_write;
  logic [4:0]  exm_rd;
  logic [31:0] exm_alu_out;
  logic        mw_reg_write;
  logic [4:0]  mw_rd;
  logic [31:0] mw_wdata;
  logic        flush;
  logic        stall, ex_valid;
  logic [5:0]  ex_op, ex_func;
  logic [4:0]  ex_shamt, ex_dest;
  logic [31:0] ex_in1, ex_in2, ex_store_data;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 0;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_op(id_op), .id_func(id_func),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_shamt(id_shamt),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_mem_to_reg(id_mem_to_reg), .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst),
    .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_alu_out(exm_alu_out),
    .mw_reg_write(mw_reg_write), .mw_rd(mw_rd), .mw_wdata(mw_wdata), .flush(flush),
    .stall(stall), .ex_valid(ex_valid), .ex_op(ex_op), .ex_func(ex_func),
    .ex_shamt(ex_shamt), .ex_in1(ex_in1), .ex_in2(ex_in2), .ex_store_data(ex_store_data),
    .ex_dest(ex_dest), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // model: the instruction currently sitting in EX
  typedef struct {
    bit         valid;
    logic [5:0] op, func;
    logic [4:0] shamt, rs, rt, dest;
    logic [31:0] rs_val, rt_val;
    logic [15:0] imm;
    bit         rw, mr, mw, m2r, asrc;
  } ex_t;

  ex_t m = '{default: 0};

  function automatic bit model_stall();
    bit reads_rt;
    reads_rt = !id_alu_src || id_mem_write;
    if (!(m.valid && m.mr && m.dest != 0 && id_valid)) return 0;
    return (m.dest == id_rs) || (reads_rt && m.dest == id_rt);
  endfunction

  function automatic logic [31:0] reg_value(input logic [4:0] r, input logic [31:0] held);
    if (r == 0) return held;
    if (exm_reg_write && exm_rd == r) return exm_alu_out;
    if (mw_reg_write && mw_rd == r) return mw_wdata;
    return held;
  endfunction

  always @(posedge clk or posedge rst) begin : model_p
    ex_t n;
    n = '{default: 0};
    if (!rst && id_valid && !flush && !model_stall()) begin
      n.valid = 1;
      n.op = id_op; n.func = id_func; n.shamt = id_shamt;
      n.rs = id_rs; n.rt = id_rt; n.imm = id_imm;
      n.dest = id_reg_dst ? id_rd : id_rt;
      n.rs_val = (mw_reg_write && mw_rd != 0 && mw_rd == id_rs) ? mw_wdata : id_rs_data;
      n.rt_val = (mw_reg_write && mw_rd != 0 && mw_rd == id_rt) ? mw_wdata : id_rt_data;
      n.rw = id_reg_write; n.mr = id_mem_read; n.mw = id_mem_write;
      n.m2r = id_mem_to_reg; n.asrc = id_alu_src;
    end
    m = n;
  end

  // scoreboard helper
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // compare process: every negedge
  always @(negedge clk) begin
    if (chk_en) begin
      logic [31:0] b;
      b = reg_value(m.rt, m.rt_val);
      check("m_stall", stall, model_stall());
      check("m_valid", ex_valid, m.valid);
      check("m_op", ex_op, m.op);
      check("m_func", ex_func, m.func);
      check("m_shamt", ex_shamt, m.shamt);
      check("m_dest", ex_dest, m.dest);
      check("m_in1", ex_in1, reg_value(m.rs, m.rs_val));
      check("m_in2", ex_in2, m.asrc ? {{16{m.imm[15]}}, m.imm} : b);
      check("m_store", ex_store_data, b);
      check("m_ctrl", {ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg},
            {m.rw, m.mr, m.mw, m.m2r});
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_id(input logic [5:0] op, input logic [5:0] func,
                          input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                          input logic [31:0] rsd, input logic [31:0] rtd, input logic [15:0] imm,
                          input logic rw, input logic mr, input logic mw, input logic m2r,
                          input logic asrc, input logic rdst);
    id_valid = 1; id_op = op; id_func = func; id_rs = rs; id_rt = rt; id_rd = rd;
    id_shamt = 5'd0; id_rs_data = rsd; id_rt_data = rtd; id_imm = imm;
    id_reg_write = rw; id_mem_read = mr; id_mem_write = mw; id_mem_to_reg = m2r;
    id_alu_src = asrc; id_reg_dst = rdst;
  endtask

  task automatic idle_id();
    drive_id(6'd0, 6'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 16'd0, 0, 0, 0, 0, 0, 0);
    id_valid = 0;
  endtask

  task automatic set_prod(input logic erw, input logic [4:0] erd, input logic [31:0] eout,
                          input logic mrw, input logic [4:0] mrd, input logic [31:0] mdat);
    exm_reg_write = erw; exm_rd = erd; exm_alu_out = eout;
    mw_reg_write = mrw; mw_rd = mrd; mw_wdata = mdat;
  endtask

  initial begin
    rst = 1; flush = 0;
    idle_id();
    set_prod(0, 0, 0, 0, 0, 0);
    repeat (2) tick();
    check("rst_valid", ex_valid, 0);
    check("rst_stall", stall, 0);
    check("rst_in1", ex_in1, 0);
    check("rst_in2", ex_in2, 0);
    check("rst_store", ex_store_data, 0);
    check("rst_dest", ex_dest, 0);
    rst = 0;
    chk_en = 1;
    tick();

    // add $3,$1,$2
    drive_id(OP_RTYPE, F_ADD, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 16'd0, 1, 0, 0, 0, 0, 1);
    tick();
    check("add_valid", ex_valid, 1);
    check("add_in1", ex_in1, 32'd5);
    check("add_in2", ex_in2, 32'd7);
    check("add_dest", ex_dest, 3);
    check("add_rw", ex_reg_write, 1);
    check("add_func", ex_func, F_ADD);

    // forwarding priority on $1
    idle_id();
    set_prod(1, 5'd1, 32'h10, 1, 5'd1, 32'h20);
    #1 check("fwd_exm_prio", ex_in1, 32'h10);
    exm_rd = 5'd0;
    #1 check("fwd_rd0_ignored", ex_in1, 32'h20);
    tick();
    set_prod(0, 0, 0, 0, 0, 0);

    // lw $4,0($2) then sub $5,$4,$1
    drive_id(OP_LW, 6'd0, 5'd2, 5'd4, 5'd0, 32'h100, 32'd0, 16'd0, 1, 1, 0, 1, 1, 0);
    tick();
    drive_id(OP_RTYPE, F_SUB, 5'd4, 5'd1, 5'd5, 32'd0, 32'd9, 16'd0, 1, 0, 0, 0, 0, 1);
    #1 check("lu_stall", stall, 1);
    tick();
    check("lu_bubble_valid", ex_valid, 0);
    check("lu_bubble_ctrl", {ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg}, 0);
    check("lu_stall_one_cycle", stall, 0);
    set_prod(1, 5'd4, 32'h100, 0, 0, 0);
    tick();
    idle_id();
    set_prod(0, 0, 0, 1, 5'd4, 32'hCAFE);
    #1 check("lu_in1_from_wb", ex_in1, 32'hCAFE);
    check("lu_in2", ex_in2, 32'd9);
    check("lu_dest", ex_dest, 5);
    tick();
    set_prod(0, 0, 0, 0, 0, 0);

    // addi $6,$0,-1
    drive_id(OP_ADDI, 6'd0, 5'd0, 5'd6, 5'd0, 32'd0, 32'd0, 16'hFFFF, 1, 0, 0, 0, 1, 0);
    tick();
    check("addi_in2", ex_in2, 32'hFFFFFFFF);
    check("addi_dest", ex_dest, 6);
    check("addi_in1", ex_in1, 0);
    // lw $6 then addi with $6 only as destination
    drive_id(OP_LW, 6'd0, 5'd0, 5'd6, 5'd0, 32'd0, 32'd0, 16'd0, 1, 1, 0, 1, 1, 0);
    tick();
    drive_id(OP_ADDI, 6'd0, 5'd7, 5'd6, 5'd0, 32'd3, 32'd0, 16'd1, 1, 0, 0, 0, 1, 0);
    #1 check("dest_only_no_stall", stall, 0);
    tick();

    // flush of a valid sw
    drive_id(OP_SW, 6'd0, 5'd1, 5'd2, 5'd0, 32'd0, 32'd0, 16'd4, 0, 0, 1, 0, 1, 0);
    flush = 1;
    tick();
    check("flush_valid", ex_valid, 0);
    check("flush_mw", ex_mem_write, 0);
    flush = 0;

    // flush together with a load-use stall
    drive_id(OP_LW, 6'd0, 5'd0, 5'd8, 5'd0, 32'd0, 32'd0, 16'd0, 1, 1, 0, 1, 1, 0);
    tick();
    drive_id(OP_RTYPE, F_SUB, 5'd8, 5'd3, 5'd9, 32'd0, 32'd0, 16'd0, 1, 0, 0, 0, 0, 1);
    flush = 1;
    #1 check("flush_stall_out", stall, 1);
    tick();
    check("flush_stall_valid", ex_valid, 0);
    check("flush_stall_ctrl", {ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg}, 0);
    flush = 0;
    idle_id();
    tick();

    // WB bypass at capture
    drive_id(OP_RTYPE, F_OR, 5'd9, 5'd10, 5'd11, 32'd1, 32'd2, 16'd0, 1, 0, 0, 0, 0, 1);
    set_prod(0, 0, 0, 1, 5'd9, 32'h55);
    tick();
    set_prod(0, 0, 0, 0, 0, 0);
    idle_id();
    #1 check("wbbyp_in1", ex_in1, 32'h55);
    check("wbbyp_in2", ex_in2, 32'd2);
    tick();

    // sw with rt forwarded from EX/MEM and negative offset
    drive_id(OP_SW, 6'd0, 5'd1, 5'd2, 5'd0, 32'h1000, 32'd0, 16'hFFFC, 0, 0, 1, 0, 1, 0);
    tick();
    idle_id();
    set_prod(1, 5'd2, 32'hBEEF, 0, 0, 0);
    #1 check("sw_store_fwd", ex_store_data, 32'hBEEF);
    check("sw_in2_imm", ex_in2, 32'hFFFFFFFC);
    check("sw_in1", ex_in1, 32'h1000);
    tick();
    set_prod(0, 0, 0, 0, 0, 0);

    // asynchronous reset mid-stream
    drive_id(OP_LW, 6'd0, 5'd0, 5'd4, 5'd0, 32'd0, 32'd0, 16'd0, 1, 1, 0, 1, 1, 0);
    tick();
    drive_id(OP_RTYPE, F_ADD, 5'd4, 5'd2, 5'd3, 32'd0, 32'd0, 16'd0, 1, 0, 0, 0, 0, 1);
    #1 check("pre_rst_stall", stall, 1);
    #1 rst = 1;
    #1 check("arst_valid", ex_valid, 0);
    check("arst_stall", stall, 0);
    check("arst_mr", ex_mem_read, 0);
    check("arst_dest", ex_dest, 0);
    check("arst_op", ex_op, 0);
    @(negedge clk);
    rst = 0;
    drive_id(OP_RTYPE, F_ADD, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 16'd0, 1, 0, 0, 0, 0, 1);
    #1 check("post_rst_empty", ex_valid, 0);
    tick();
    check("post_rst_valid", ex_valid, 1);
    check("post_rst_in1", ex_in1, 32'd5);
    idle_id();
    repeat (2) tick();

    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
